// File: rtl/ahb_master_arbiter.sv
// Two-master (instruction/data) to one-slave AHB-Lite arbiter. A master that loses
// arbitration has its address phase parked in a holding register and is stalled
// through HREADY until the held transfer is replayed to the slave.
module ahb_master_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  // master 0: instruction port
  input  logic [ADDR_WIDTH-1:0] M0_HADDR,
  input  logic [1:0]            M0_HTRANS,
  input  logic                  M0_HWRITE,
  input  logic                  M0_HMASTLOCK,
  input  logic [2:0]            M0_HSIZE,
  input  logic [DATA_WIDTH-1:0] M0_HWDATA,
  output logic [DATA_WIDTH-1:0] M0_HRDATA,
  output logic                  M0_HREADY,
  output logic                  M0_HRESP,
  // master 1: data port
  input  logic [ADDR_WIDTH-1:0] M1_HADDR,
  input  logic [1:0]            M1_HTRANS,
  input  logic                  M1_HWRITE,
  input  logic                  M1_HMASTLOCK,
  input  logic [2:0]            M1_HSIZE,
  input  logic [DATA_WIDTH-1:0] M1_HWDATA,
  output logic [DATA_WIDTH-1:0] M1_HRDATA,
  output logic                  M1_HREADY,
  output logic                  M1_HRESP,
  // shared slave
  output logic                  S_HSEL,
  output logic [ADDR_WIDTH-1:0] S_HADDR,
  output logic [1:0]            S_HTRANS,
  output logic                  S_HWRITE,
  output logic [2:0]            S_HSIZE,
  output logic                  S_HMASTLOCK,
  output logic [DATA_WIDTH-1:0] S_HWDATA,
  input  logic [DATA_WIDTH-1:0] S_HRDATA,
  input  logic                  S_HREADYOUT,
  input  logic                  S_HRESP,
  output logic                  S_HREADY
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {DP_IDLE, DP_OWN_M0, DP_OWN_M1} dp_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [2:0]            size;
    logic                  lock;
  } xfer_t;

  xfer_t     live [2];
  xfer_t     hold_q [2];
  logic [1:0] pend_q;
  logic [1:0] hready;
  logic [1:0] live_req;
  logic [1:0] req;
  logic [1:0] grant_vec;
  logic [1:0] capture;
  logic       grant_valid;
  logic       winner;
  xfer_t      sel_xfer;
  logic       last_grant;
  logic       lock_q;
  logic       lock_owner;
  dp_state_t  dp_state;
  dp_state_t  dp_next;

  assign live[0] = '{addr: M0_HADDR, write: M0_HWRITE, size: M0_HSIZE, lock: M0_HMASTLOCK};
  assign live[1] = '{addr: M1_HADDR, write: M1_HWRITE, size: M1_HSIZE, lock: M1_HMASTLOCK};

  // A master stalled on a parked transfer must not have its next address counted.
  assign hready[0] = (dp_state == DP_OWN_M0) ? S_HREADYOUT : !pend_q[0];
  assign hready[1] = (dp_state == DP_OWN_M1) ? S_HREADYOUT : !pend_q[1];

  assign live_req = {M1_HTRANS[1] & hready[1], M0_HTRANS[1] & hready[0]};
  assign req      = live_req | pend_q;

  // Gating with HRESETn keeps the slave idle while reset is held.
  always_comb begin
    grant_valid = HRESETn && S_HREADYOUT && (req != 2'b00);
    if (lock_q && req[lock_owner])
      winner = lock_owner;
    else if (req == 2'b11)
      winner = (FIXED_PRIO != 0) ? 1'b1 : !last_grant;
    else
      winner = req[1];
    sel_xfer  = pend_q[winner] ? hold_q[winner] : live[winner];
    grant_vec = grant_valid ? (winner ? 2'b10 : 2'b01) : 2'b00;
    capture   = live_req & ~grant_vec;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q     <= 2'b00;
      lock_q     <= 1'b0;
      lock_owner <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      pend_q <= (pend_q & ~grant_vec) | capture;
      if (grant_valid) begin
        lock_q     <= sel_xfer.lock;
        lock_owner <= winner;
        if (req == 2'b11)
          last_grant <= winner;
      end else if (S_HREADYOUT) begin
        lock_q <= 1'b0;
      end
    end
  end

  // NOTE: the holding registers are pure datapath qualified by pend_q, so they carry no reset.
  always_ff @(posedge HCLK) begin
    if (capture[0]) hold_q[0] <= live[0];
    if (capture[1]) hold_q[1] <= live[1];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp_state <= DP_IDLE;
    else          dp_state <= dp_next;
  end

  always_comb begin
    dp_next = dp_state;
    if (S_HREADYOUT) begin
      if (!grant_valid)  dp_next = DP_IDLE;
      else if (winner)   dp_next = DP_OWN_M1;
      else               dp_next = DP_OWN_M0;
    end
  end

  assign S_HSEL      = grant_valid;
  assign S_HTRANS    = grant_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign S_HADDR     = sel_xfer.addr;
  assign S_HWRITE    = sel_xfer.write;
  assign S_HSIZE     = sel_xfer.size;
  assign S_HMASTLOCK = grant_valid & sel_xfer.lock;
  assign S_HWDATA    = (dp_state == DP_OWN_M1) ? M1_HWDATA : M0_HWDATA;
  assign S_HREADY    = S_HREADYOUT;

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HREADY = hready[0];
  assign M1_HREADY = hready[1];
  assign M0_HRESP  = (dp_state == DP_OWN_M0) & S_HRESP;
  assign M1_HRESP  = (dp_state == DP_OWN_M1) & S_HRESP;

  // SEQ is forwarded as NONSEQ, so HTRANS[0] carries no information here.
  logic unused_htrans;
  assign unused_htrans = M0_HTRANS[0] ^ M1_HTRANS[0];

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: a round-robin and a fixed-priority instance
// share stimulus; vectors and hand sequences carry precomputed expectations.
module tb_ahb_master_arbiter;

  localparam logic [1:0]  NS = 2'b10;
  localparam logic [1:0]  ID = 2'b00;
  localparam logic [31:0] W0 = 32'h0000_1111;
  localparam logic [31:0] RD = 32'hDEAD_0200;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
  logic [1:0]  m0_trans, m1_trans;
  logic        m0_write, m1_write, m0_lock, m1_lock, s_readyout, s_resp;
  logic [2:0]  m0_size, m1_size;

  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_haddr, rr_hwdata;
  logic        rr_m0_ready, rr_m1_ready, rr_m0_resp, rr_m1_resp;
  logic        rr_sel, rr_write, rr_lock, rr_sready;
  logic [1:0]  rr_trans;
  logic [2:0]  rr_size;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_haddr, fp_hwdata;
  logic        fp_m0_ready, fp_m1_ready, fp_m0_resp, fp_m1_resp;
  logic        fp_sel, fp_write, fp_lock, fp_sready;
  logic [1:0]  fp_trans;
  logic [2:0]  fp_size;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter #(.FIXED_PRIO(0), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(m0_addr), .M0_HTRANS(m0_trans), .M0_HWRITE(m0_write), .M0_HMASTLOCK(m0_lock),
    .M0_HSIZE(m0_size), .M0_HWDATA(m0_wdata), .M0_HRDATA(rr_m0_rdata),
    .M0_HREADY(rr_m0_ready), .M0_HRESP(rr_m0_resp),
    .M1_HADDR(m1_addr), .M1_HTRANS(m1_trans), .M1_HWRITE(m1_write), .M1_HMASTLOCK(m1_lock),
    .M1_HSIZE(m1_size), .M1_HWDATA(m1_wdata), .M1_HRDATA(rr_m1_rdata),
    .M1_HREADY(rr_m1_ready), .M1_HRESP(rr_m1_resp),
    .S_HSEL(rr_sel), .S_HADDR(rr_haddr), .S_HTRANS(rr_trans), .S_HWRITE(rr_write),
    .S_HSIZE(rr_size), .S_HMASTLOCK(rr_lock), .S_HWDATA(rr_hwdata), .S_HRDATA(s_rdata),
    .S_HREADYOUT(s_readyout), .S_HRESP(s_resp), .S_HREADY(rr_sready)
  );

  ahb_master_arbiter #(.FIXED_PRIO(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(m0_addr), .M0_HTRANS(m0_trans), .M0_HWRITE(m0_write), .M0_HMASTLOCK(m0_lock),
    .M0_HSIZE(m0_size), .M0_HWDATA(m0_wdata), .M0_HRDATA(fp_m0_rdata),
    .M0_HREADY(fp_m0_ready), .M0_HRESP(fp_m0_resp),
    .M1_HADDR(m1_addr), .M1_HTRANS(m1_trans), .M1_HWRITE(m1_write), .M1_HMASTLOCK(m1_lock),
    .M1_HSIZE(m1_size), .M1_HWDATA(m1_wdata), .M1_HRDATA(fp_m1_rdata),
    .M1_HREADY(fp_m1_ready), .M1_HRESP(fp_m1_resp),
    .S_HSEL(fp_sel), .S_HADDR(fp_haddr), .S_HTRANS(fp_trans), .S_HWRITE(fp_write),
    .S_HSIZE(fp_size), .S_HMASTLOCK(fp_lock), .S_HWDATA(fp_hwdata), .S_HRDATA(s_rdata),
    .S_HREADYOUT(s_readyout), .S_HRESP(s_resp), .S_HREADY(fp_sready)
  );

  typedef struct {
    logic [1:0]  m0_trans;
    logic [31:0] m0_addr;
    logic [1:0]  m1_trans;
    logic [31:0] m1_addr;
    logic        m1_write;
    logic [31:0] m1_wdata;
    logic        ro;
    logic        e_sel;
    logic [31:0] e_addr;
    logic        e_write;
    logic [31:0] e_wdata;
    logic        e_m0r;
    logic        e_m1r;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    m0_trans = ID; m1_trans = ID; m0_addr = '0; m1_addr = '0;
    m0_write = 1'b0; m1_write = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    m0_size = 3'b010; m1_size = 3'b010; m0_wdata = W0; m1_wdata = '0;
    s_readyout = 1'b1; s_resp = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    HRESETn = 1'b0;
    set_idle();
    next_cycle();
    HRESETn = 1'b1;
  endtask

  initial begin
    // master, slave-side expectations hand-derived cycle by cycle
    vecs[0]  = '{NS, 32'h200, ID, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h200,        1'b0, W0,           1'b1, 1'b1};
    vecs[1]  = '{ID, 32'h0,   ID, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b0, W0,           1'b1, 1'b1};
    vecs[2]  = '{NS, 32'h200, NS, 32'h1C010004, 1'b1, 32'h0,        1'b1, 1'b1, 32'h200,        1'b0, W0,           1'b1, 1'b1};
    vecs[3]  = '{ID, 32'h0,   ID, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 32'h1C010004,   1'b1, W0,           1'b1, 1'b0};
    vecs[4]  = '{ID, 32'h0,   ID, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0,          1'b0, 32'hCAFEF00D, 1'b1, 1'b1};
    vecs[5]  = '{NS, 32'h10,  NS, 32'h20,       1'b0, 32'h0,        1'b1, 1'b1, 32'h20,         1'b0, W0,           1'b1, 1'b1};
    vecs[6]  = '{NS, 32'h14,  NS, 32'h24,       1'b0, 32'h0,        1'b1, 1'b1, 32'h10,         1'b0, 32'h0,        1'b0, 1'b1};
    vecs[7]  = '{NS, 32'h14,  NS, 32'h28,       1'b0, 32'h0,        1'b1, 1'b1, 32'h24,         1'b0, W0,           1'b1, 1'b0};
    vecs[8]  = '{ID, 32'h0,   ID, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h14,         1'b0, 32'h0,        1'b0, 1'b1};
    vecs[9]  = '{ID, 32'h0,   ID, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b0, W0,           1'b1, 1'b1};
    vecs[10] = '{ID, 32'h0,   NS, 32'h300,      1'b0, 32'h0,        1'b1, 1'b1, 32'h300,        1'b0, W0,           1'b1, 1'b1};
    vecs[11] = '{NS, 32'h400, ID, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        1'b1, 1'b0};
    vecs[12] = '{ID, 32'h0,   ID, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,          1'b0, 32'h0,        1'b0, 1'b0};
    vecs[13] = '{ID, 32'h0,   ID, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h400,        1'b0, 32'h0,        1'b0, 1'b1};
    vecs[14] = '{ID, 32'h0,   ID, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b0, W0,           1'b1, 1'b1};

    // reset state, with masters already requesting
    set_idle();
    s_rdata  = RD;
    HRESETn  = 1'b0;
    m0_trans = NS; m0_addr = 32'h123; s_resp = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_sel", 32'(rr_sel), 32'd0);
    check("rst_trans", 32'(rr_trans), 32'd0);
    check("rst_m0_ready", 32'(rr_m0_ready), 32'd1);
    check("rst_m1_ready", 32'(rr_m1_ready), 32'd1);
    check("rst_m0_resp", 32'(rr_m0_resp), 32'd0);
    check("rst_fp_sel", 32'(fp_sel), 32'd0);
    next_cycle();
    HRESETn = 1'b1;
    set_idle();

    // round-robin vectors
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      m0_trans = vecs[i].m0_trans; m0_addr = vecs[i].m0_addr;
      m1_trans = vecs[i].m1_trans; m1_addr = vecs[i].m1_addr;
      m1_write = vecs[i].m1_write; m1_wdata = vecs[i].m1_wdata;
      s_readyout = vecs[i].ro;
      @(negedge HCLK);
      check($sformatf("v%0d_sel", i), 32'(rr_sel), 32'(vecs[i].e_sel));
      check($sformatf("v%0d_trans", i), 32'(rr_trans), vecs[i].e_sel ? 32'd2 : 32'd0);
      if (vecs[i].e_sel) begin
        check($sformatf("v%0d_haddr", i), rr_haddr, vecs[i].e_addr);
        check($sformatf("v%0d_hwrite", i), 32'(rr_write), 32'(vecs[i].e_write));
      end
      check($sformatf("v%0d_hwdata", i), rr_hwdata, vecs[i].e_wdata);
      check($sformatf("v%0d_m0_ready", i), 32'(rr_m0_ready), 32'(vecs[i].e_m0r));
      check($sformatf("v%0d_m1_ready", i), 32'(rr_m1_ready), 32'(vecs[i].e_m1r));
      check($sformatf("v%0d_sready", i), 32'(rr_sready), 32'(vecs[i].ro));
    end
    check("m0_hrdata", rr_m0_rdata, RD);
    check("m1_hrdata", rr_m1_rdata, RD);

    // fixed priority: data port keeps winning, instruction port stalls
    do_reset();
    next_cycle();
    m0_trans = NS; m0_addr = 32'h500; m1_trans = NS; m1_addr = 32'h600;
    @(negedge HCLK);
    check("fp_c0_haddr", fp_haddr, 32'h600);
    check("fp_c0_m0_ready", 32'(fp_m0_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      m1_addr = 32'h600 + 32'(4 * k);
      @(negedge HCLK);
      check($sformatf("fp_c%0d_haddr", k), fp_haddr, 32'h600 + 32'(4 * k));
      check($sformatf("fp_c%0d_m0_ready", k), 32'(fp_m0_ready), 32'd0);
    end
    next_cycle();
    m1_trans = ID; m0_addr = 32'h504;
    @(negedge HCLK);
    check("fp_c4_haddr", fp_haddr, 32'h500);
    check("fp_c4_sel", 32'(fp_sel), 32'd1);
    check("fp_c4_m0_ready", 32'(fp_m0_ready), 32'd0);
    next_cycle();
    m0_trans = ID;
    @(negedge HCLK);
    check("fp_c5_m0_ready", 32'(fp_m0_ready), 32'd1);

    // locked sequence holds the grant against round-robin; HRESP routing
    do_reset();
    next_cycle();
    m1_trans = NS; m1_addr = 32'h700; m1_lock = 1'b1;
    @(negedge HCLK);
    check("lk0_haddr", rr_haddr, 32'h700);
    check("lk0_mastlock", 32'(rr_lock), 32'd1);
    next_cycle();
    m0_trans = NS; m0_addr = 32'h800; m1_addr = 32'h704; s_resp = 1'b1;
    @(negedge HCLK);
    check("lk1_haddr", rr_haddr, 32'h704);
    check("lk1_mastlock", 32'(rr_lock), 32'd1);
    check("lk1_m1_resp", 32'(rr_m1_resp), 32'd1);
    check("lk1_m0_resp", 32'(rr_m0_resp), 32'd0);
    next_cycle();
    m0_trans = ID; m1_trans = ID; m1_lock = 1'b0; s_resp = 1'b0;
    @(negedge HCLK);
    check("lk2_haddr", rr_haddr, 32'h800);
    check("lk2_mastlock", 32'(rr_lock), 32'd0);
    check("lk2_m0_ready", 32'(rr_m0_ready), 32'd0);

    // reset asserted with pend0 set and M1 owning the data phase
    do_reset();
    next_cycle();
    m1_trans = NS; m1_addr = 32'h900;
    @(negedge HCLK);
    check("rm0_haddr", rr_haddr, 32'h900);
    next_cycle();
    m1_trans = ID; m0_trans = NS; m0_addr = 32'hA00; s_readyout = 1'b0;
    @(negedge HCLK);
    check("rm1_m0_ready", 32'(rr_m0_ready), 32'd1);
    check("rm1_m1_ready", 32'(rr_m1_ready), 32'd0);
    check("rm1_sel", 32'(rr_sel), 32'd0);
    next_cycle();
    m0_addr = 32'hA04; s_readyout = 1'b1;
    #1;
    check("rm2_m0_ready", 32'(rr_m0_ready), 32'd0);
    check("rm2_haddr", rr_haddr, 32'hA00);
    #2;
    HRESETn = 1'b0;
    #1;
    check("rm_rst_sel", 32'(rr_sel), 32'd0);
    check("rm_rst_trans", 32'(rr_trans), 32'd0);
    check("rm_rst_m0_ready", 32'(rr_m0_ready), 32'd1);
    check("rm_rst_m1_ready", 32'(rr_m1_ready), 32'd1);
    next_cycle();
    HRESETn = 1'b1;
    m0_trans = ID;
    @(negedge HCLK);
    check("rm_post_sel", 32'(rr_sel), 32'd0);
    check("rm_post_m0_ready", 32'(rr_m0_ready), 32'd1);
    next_cycle();
    @(negedge HCLK);
    check("rm_post2_sel", 32'(rr_sel), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin and 1 = master 1 (data port) always wins.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning address width of all ports.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning read/write data width.
REQ-004 SHALL have port HCLK  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port HRESETn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports M<n>_HADDR  in  ADDR_WIDTH  master n address (n=0 instruction, n=1 data).
REQ-007 SHALL have ports M<n>_HTRANS  in  2  master n transfer type.
REQ-008 SHALL have ports M<n>_HWRITE/M<n>_HMASTLOCK  in  1  master n write and lock.
REQ-009 SHALL have ports M<n>_HSIZE  in  3  master n transfer size.
REQ-010 SHALL have ports M<n>_HWDATA  in  DATA_WIDTH  master n write data.
REQ-011 SHALL have ports M<n>_HRDATA  out  DATA_WIDTH  read data, equal to S_HRDATA for both masters.
REQ-012 SHALL have ports M<n>_HREADY/M<n>_HRESP  out  1  master n ready and response.
REQ-013 SHALL have ports S_HSEL/S_HWRITE/S_HMASTLOCK  out  1  shared slave select, write and lock.
REQ-014 SHALL have ports S_HADDR  out  ADDR_WIDTH, S_HTRANS  out  2, S_HSIZE  out  3, S_HWDATA  out  DATA_WIDTH: shared slave address/control/write data.
REQ-015 SHALL have ports S_HRDATA  in  DATA_WIDTH, S_HREADYOUT  in  1, S_HRESP  in  1: slave return path.
REQ-016 SHALL have port S_HREADY  out  1  slave-side HREADY, equal to S_HREADYOUT.

Function
REQ-017 SHALL treat master n as requesting in a cycle when M<n>_HTRANS[1]=1 and M<n>_HREADY=1, or when pend<n>=1.
REQ-018 SHALL keep one holding register per master: pend<n>, address, write, size and lock.
REQ-019 SHALL arbitrate only in cycles where S_HREADYOUT=1 (slave address slot open).
REQ-020 SHALL grant the winner; the winner's pending register, if valid, takes precedence over its live bus.
REQ-021 SHALL drive the granted address/control to the slave with S_HSEL=1 and S_HTRANS=NONSEQ.
REQ-022 SHALL capture a non-granted requester's live address phase into its holding register and set pend<n>.
REQ-023 SHALL clear pend<n> in the cycle its held transfer is granted.
REQ-024 SHALL, with FIXED_PRIO=0 and both requesting, grant the master not granted last (last_grant toggles on each contested grant).
REQ-025 SHALL, with FIXED_PRIO=1, grant master 1 whenever master 1 requests.
REQ-026 SHALL keep the grant on the current master while that master's granted transfer had HMASTLOCK=1 and it keeps requesting, regardless of arbitration.
REQ-027 SHALL, with no requester, drive S_HTRANS=IDLE, S_HSEL=0 and S_HMASTLOCK=0.
REQ-028 SHALL hold data-phase state dp_state in IDLE, OWN_M0 or OWN_M1.
REQ-029 SHALL, on a granted address phase, set dp_state to OWN_<winner>; otherwise IDLE. Update occurs only when S_HREADYOUT=1.
REQ-030 SHALL mux S_HWDATA from the dp_state owner; IDLE drives master 0 data.
REQ-031 SHALL set M<n>_HREADY = S_HREADYOUT if dp_state=OWN_Mn; 0 if pend<n>=1; otherwise 1.
REQ-032 SHALL set M<n>_HRESP = S_HRESP when dp_state=OWN_Mn, else 0.
REQ-033 SHALL add zero wait states for an uncontested transfer and one wait cycle per transfer ahead of a stalled master.
REQ-034 SHALL never drop a captured request; master n keeps HWDATA stable while M<n>_HREADY=0.

Reset
REQ-035 SHALL, while HRESETn=0, clear pend0/pend1 and lock hold, set dp_state=IDLE and last_grant=1 (master 0 wins the first contest).
REQ-036 SHALL, during reset, drive outputs as S_HSEL=0, S_HTRANS=IDLE, M<n>_HREADY=1 and M<n>_HRESP=0.
REQ-037 SHALL, when reset is asserted mid-transfer, abandon all pending and in-flight transfers immediately, with no completion after release.

Verification
REQ-038 SHALL cover: M0 only, NONSEQ read of 0x200, slave zero-wait -> S_HADDR=0x200 same cycle, M0_HREADY=1 next cycle with S_HRDATA.
REQ-039 SHALL cover: M0 read 0x200 and M1 write 0x1C010004/0xCAFEF00D in the same cycle, FIXED_PRIO=0, after reset -> M0 granted first; M1 pended with M1_HREADY=0 one cycle; then S_HADDR=0x1C010004 and S_HWDATA=0xCAFEF00D.
REQ-040 SHALL cover: repeated simultaneous requests, FIXED_PRIO=0 -> grants alternate M0,M1,M0,M1.
REQ-041 SHALL cover: FIXED_PRIO=1 with continuous requests from both -> M1 always granted; M0_HREADY stays 0 until M1 goes IDLE.
REQ-042 SHALL cover: slave inserts 2 wait states (S_HREADYOUT=0) during an M1 data phase while M0 requests -> no grant change; M0 captured and granted on the first S_HREADYOUT=1.
REQ-043 SHALL cover: HRESETn pulled low with pend0=1 and dp_state=OWN_M1 -> next sampled cycle pend0=0, S_HTRANS=IDLE, both HREADY=1.
